// File: rtl/ppi_bus_ctrl_if.sv
// Requester handshake and PPI strobe/address signals of ppi_bus_ctrl.
// The PPI data bus stays a plain inout port on the controller so it can be tri-stated.
interface ppi_bus_ctrl_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_rdata;
    logic        CS_;
    logic        RD_;
    logic        WR_;
    logic [1:0]  A;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, CS_, RD_, WR_, A
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, CS_, RD_, WR_, A
    );
endinterface

// File: rtl/ppi_bus_ctrl.sv
// Host-side controller for an 8255-style PPI: round-robin arbitration of two
// requesters and one SETUP/STROBE/HOLD bus cycle per accepted access.
module ppi_bus_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    ppi_bus_ctrl_if.slave  bus,
    inout  wire [7:0]      D
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  a_q, a_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        d_oe_q, d_oe_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    logic        any_req;
    logic        gnt_id;
    logic [1:0]  ready;

    // Both valid: the requester not granted last time wins.
    always_comb begin
        gnt_id  = 1'b0;
        any_req = |bus.req_valid;
        unique case (bus.req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_q;
            default: gnt_id = 1'b0;
        endcase
        ready = 2'b00;
        if (state_q == IDLE && !RESET && any_req) begin
            ready = gnt_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        a_d         = a_q;
        wdata_d     = wdata_q;
        id_d        = id_q;
        last_d      = last_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        d_oe_d      = d_oe_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;

        // Bus pins are registered, so each branch sets the levels of the state being entered.
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    wr_d    = bus.req_wr[gnt_id];
                    a_d     = gnt_id ? bus.req_addr[3:2] : bus.req_addr[1:0];
                    wdata_d = gnt_id ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    cs_n_d  = 1'b0;
                    d_oe_d  = bus.req_wr[gnt_id];
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    rd_n_d  = wr_q;
                    wr_n_d  = ~wr_q;
                    cnt_d   = STROBE_LD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = D;
                    end
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d      = 1'b1;
                    d_oe_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_rdata_d = wr_q ? 8'h00 : rdata_q;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            a_q         <= '0;
            wdata_q     <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            d_oe_q      <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            a_q         <= a_d;
            wdata_q     <= wdata_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            d_oe_q      <= d_oe_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.CS_       = cs_n_q;
    assign bus.RD_       = rd_n_q;
    assign bus.WR_       = wr_n_q;
    assign bus.A         = a_q;
    assign D             = d_oe_q ? wdata_q : 'z;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Scoreboard bench for ppi_bus_ctrl: default-timing instance (0) and a 2/3/2 timing instance (1).
module tb_ppi_bus_ctrl;

    typedef struct packed {
        logic        inst;
        logic        id;
        logic [7:0]  rdata;
        logic [31:0] cyc;
    } rsp_t;

    typedef struct packed {
        logic       inst;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] cs_len;
        logic [7:0] st_len;
        logic [7:0] st_off;
    } bus_t;

    logic CLK;
    logic RESET;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic mon_en;
    logic rd_drv;
    logic [7:0] rd_val;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    ppi_bus_ctrl_if bus0 ();
    ppi_bus_ctrl_if bus1 ();
    wire [7:0] d_net0;
    wire [7:0] d_net1;

    ppi_bus_ctrl dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0), .D(d_net0));
    ppi_bus_ctrl #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1), .D(d_net1));

    // Bench acts as the PPI port returning read data while RD_ is low.
    assign d_net0 = (rd_drv && !bus0.RD_) ? rd_val : 8'bz;

    wire [1:0] csv = {bus1.CS_, bus0.CS_};
    wire [1:0] rdv = {bus1.RD_, bus0.RD_};
    wire [1:0] wrv = {bus1.WR_, bus0.WR_};
    wire [1:0] oev = {dut1.d_oe_q, dut0.d_oe_q};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int inst, input logic [1:0] v, input logic [1:0] w,
                         input logic [3:0] a, input logic [15:0] wd);
        if (inst == 0) begin
            bus0.req_valid = v; bus0.req_wr = w; bus0.req_addr = a; bus0.req_wdata = wd;
        end else begin
            bus1.req_valid = v; bus1.req_wr = w; bus1.req_addr = a; bus1.req_wdata = wd;
        end
    endtask

    // Waits for the handshake, checks the grant and queues the expected bus cycle and response.
    task automatic hs(input int inst, input logic [1:0] exp_rdy, input logic id, input logic wr,
                      input logic [1:0] addr, input logic [7:0] data, input logic [7:0] rdata,
                      input int s, input int st, input int h);
        int k;
        logic [1:0] r;
        rsp_t er;
        bus_t eb;
        k = 0;
        do begin
            @(negedge CLK);
            r = (inst == 0) ? bus0.req_ready : bus1.req_ready;
            k++;
        end while (r == 2'b00 && k < 50);
        check("grant", {30'd0, r}, {30'd0, exp_rdy});
        if (r != 2'b00) begin
            er.inst = inst[0]; er.id = id; er.rdata = rdata; er.cyc = 32'(cyc + 1 + s + st + h);
            eb.inst = inst[0]; eb.wr = wr; eb.addr = addr; eb.data = data;
            eb.cs_len = 8'(s + st + h); eb.st_len = 8'(st); eb.st_off = 8'(s);
            rsp_q.push_back(er);
            bus_q.push_back(eb);
        end
        @(posedge CLK);
        #1;
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        logic rv, rid;
        logic [7:0] rdat;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                for (int i = 0; i < 2; i++) begin
                    rv   = (i == 0) ? bus0.rsp_valid : bus1.rsp_valid;
                    rid  = (i == 0) ? bus0.rsp_id    : bus1.rsp_id;
                    rdat = (i == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
                    if (rv) begin
                        if (rsp_q.size() == 0) begin
                            check("rsp_unexpected", 1, 0);
                        end else begin
                            e = rsp_q.pop_front();
                            check("rsp_inst", i, {31'd0, e.inst});
                            check("rsp_id", {31'd0, rid}, {31'd0, e.id});
                            check("rsp_rdata", {24'd0, rdat}, {24'd0, e.rdata});
                            check("rsp_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    // Bus-cycle monitor: measures each CS_ low window
    logic       in_win [2];
    int         cs_len [2];
    int         st_len [2];
    int         st_off [2];
    int         oe_cnt [2];
    logic       wr_seen [2];
    logic       rd_seen [2];
    logic [7:0] d_val [2];
    logic       d_ok [2];
    logic [1:0] a_val [2];
    logic       a_ok [2];

    initial begin
        bus_t e;
        logic [7:0] dv;
        logic [1:0] av;
        in_win[0] = 1'b0;
        in_win[1] = 1'b0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                dv = (i == 0) ? d_net0 : d_net1;
                av = (i == 0) ? bus0.A : bus1.A;
                if (RESET || !mon_en) begin
                    in_win[i] = 1'b0;
                end else if (!csv[i]) begin
                    if (!in_win[i]) begin
                        in_win[i] = 1'b1; cs_len[i] = 0; st_len[i] = 0; st_off[i] = 255;
                        oe_cnt[i] = 0; wr_seen[i] = 1'b0; rd_seen[i] = 1'b0;
                        d_val[i] = dv; d_ok[i] = 1'b1; a_val[i] = av; a_ok[i] = 1'b1;
                    end
                    if (!wrv[i] || !rdv[i]) begin
                        if (st_off[i] == 255) st_off[i] = cs_len[i];
                        st_len[i]++;
                    end
                    if (!wrv[i]) wr_seen[i] = 1'b1;
                    if (!rdv[i]) rd_seen[i] = 1'b1;
                    if (oev[i]) begin
                        oe_cnt[i]++;
                        if (dv !== d_val[i]) d_ok[i] = 1'b0;
                    end
                    if (av !== a_val[i]) a_ok[i] = 1'b0;
                    cs_len[i]++;
                end else if (in_win[i]) begin
                    in_win[i] = 1'b0;
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected", 1, 0);
                    end else begin
                        e = bus_q.pop_front();
                        check("bus_inst", i, {31'd0, e.inst});
                        check("bus_cs_len", cs_len[i], {24'd0, e.cs_len});
                        check("bus_strobe_len", st_len[i], {24'd0, e.st_len});
                        check("bus_strobe_off", st_off[i], {24'd0, e.st_off});
                        check("bus_strobe_kind", {30'd0, wr_seen[i], rd_seen[i]},
                              e.wr ? 32'd2 : 32'd1);
                        check("bus_addr", {29'd0, a_ok[i], a_val[i]}, {29'd0, 1'b1, e.addr});
                        check("bus_d_drive_cycles", oe_cnt[i], e.wr ? {24'd0, e.cs_len} : 32'd0);
                        if (e.wr) check("bus_wdata", {23'd0, d_ok[i], d_val[i]}, {23'd0, 1'b1, e.data});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        cyc = 0; n_checks = 0; n_errors = 0;
        RESET = 1'b1; mon_en = 1'b1; rd_drv = 1'b0; rd_val = 8'h00;
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        drive(1, 2'b00, 2'b00, 4'h0, 16'h0000);

        // Reset held: requests must be ignored and the bus idle
        for (int n = 0; n < 6; n++) begin
            @(posedge CLK); #1;
            bus0.req_valid = 2'($urandom_range(1, 3));
            bus1.req_valid = 2'($urandom_range(1, 3));
            bus0.req_wr = 2'b11;
            @(negedge CLK);
            check("reset_quiet",
                  {18'd0, bus0.CS_, bus0.RD_, bus0.WR_, oev[0], bus0.req_ready, bus0.rsp_valid,
                   bus1.CS_, bus1.RD_, bus1.WR_, oev[1], bus1.req_ready, bus1.rsp_valid},
                  {18'd0, 3'b111, 1'b0, 2'b00, 1'b0, 3'b111, 1'b0, 2'b00, 1'b0});
        end
        check("reset_addr", {30'd0, bus0.A}, 32'd0);
        @(posedge CLK); #1;
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        drive(1, 2'b00, 2'b00, 4'h0, 16'h0000);
        RESET = 1'b0;
        repeat (2) @(posedge CLK); #1;

        // req0 write to control register
        drive(0, 2'b01, 2'b01, 4'b0011, 16'h009B);
        hs(0, 2'b01, 1'b0, 1'b1, 2'd3, 8'h9B, 8'h00, 1, 2, 1);
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        repeat (8) @(posedge CLK); #1;

        // req1 read of port A
        rd_val = 8'hE7; rd_drv = 1'b1;
        drive(0, 2'b10, 2'b00, 4'b0000, 16'h0000);
        hs(0, 2'b10, 1'b1, 1'b0, 2'd0, 8'h00, 8'hE7, 1, 2, 1);
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        repeat (8) @(posedge CLK); #1;
        rd_drv = 1'b0;

        // Both requesters valid continuously: alternate grants
        drive(0, 2'b11, 2'b11, 4'b0101, 16'h2211);
        hs(0, 2'b01, 1'b0, 1'b1, 2'd1, 8'h11, 8'h00, 1, 2, 1);
        hs(0, 2'b10, 1'b1, 1'b1, 2'd1, 8'h22, 8'h00, 1, 2, 1);
        hs(0, 2'b01, 1'b0, 1'b1, 2'd1, 8'h11, 8'h00, 1, 2, 1);
        hs(0, 2'b10, 1'b1, 1'b1, 2'd1, 8'h22, 8'h00, 1, 2, 1);
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        repeat (10) @(posedge CLK); #1;

        // Reset during STROBE of a write: access dropped, priority back to req0
        drive(0, 2'b01, 2'b01, 4'b0010, 16'h005A);
        k = 0;
        do begin @(negedge CLK); k++; end while (bus0.req_ready == 2'b00 && k < 50);
        check("abort_grant", {30'd0, bus0.req_ready}, 32'd1);
        @(posedge CLK); #1;
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        mon_en = 1'b0;
        k = 0;
        do begin @(negedge CLK); k++; end while (bus0.WR_ && k < 20);
        check("abort_strobe_seen", {31'd0, bus0.WR_}, 32'd0);
        RESET = 1'b1;
        #1;
        check("abort_pins", {28'd0, bus0.CS_, bus0.WR_, bus0.RD_, oev[0]}, 32'hE);
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            check("abort_quiet", {29'd0, bus0.rsp_valid, bus0.CS_, oev[0]}, 32'd2);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        mon_en = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            check("abort_no_rsp", {31'd0, bus0.rsp_valid}, 32'd0);
        end
        @(posedge CLK); #1;
        drive(0, 2'b11, 2'b11, 4'b1001, 16'h4433);
        hs(0, 2'b01, 1'b0, 1'b1, 2'd1, 8'h33, 8'h00, 1, 2, 1);
        drive(0, 2'b00, 2'b00, 4'h0, 16'h0000);
        repeat (10) @(posedge CLK); #1;

        // Longer timing instance
        drive(1, 2'b01, 2'b01, 4'b0010, 16'h00C3);
        hs(1, 2'b01, 1'b0, 1'b1, 2'd2, 8'hC3, 8'h00, 2, 3, 2);
        drive(1, 2'b00, 2'b00, 4'h0, 16'h0000);

        k = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && k < 100) begin
            @(posedge CLK);
            k++;
        end
        repeat (3) @(posedge CLK);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
